// File: rtl/l0_loader_pkg.sv
// Shared types and sizing for the L0 activation loader.
package l0_loader_pkg;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

   localparam int SKID_DEPTH = 2;
   localparam int STALL_W    = 16;

endpackage

// File: rtl/l0_skid_buf.sv
// Two-entry FIFO that catches SRAM read data while L0 is back-pressuring.
module l0_skid_buf
   import l0_loader_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [1:0]       o_occ,
   output logic [WIDTH-1:0] o_head
);

   logic [SKID_DEPTH-1:0][WIDTH-1:0] r_mem;
   logic                             r_rd_ptr;
   logic                             r_wr_ptr;
   logic [1:0]                       r_occ;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_mem    <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_occ    <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) r_rd_ptr <= ~r_rd_ptr;
         // Push and pop together leave occupancy unchanged.
         r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_occ  = r_occ;
   assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/l0_loader.sv
// Streams num_vec activation vectors from SRAM into the L0 FIFO bank.
// Optional stall counter port enabled by defining L0_LOADER_PERF_EN.
module l0_loader
   import l0_loader_pkg::*;
#(
   parameter int ROW    = 8,
   parameter int BW     = 4,
   parameter int ADDR_W = 11
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W-1:0] i_num_vec,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_sram_cen,
   output logic [ADDR_W-1:0] o_sram_addr,
   input  logic [ROW*BW-1:0] i_sram_q,
   input  logic              i_l0_full,
   output logic              o_l0_wr,
   output logic [ROW*BW-1:0] o_l0_in
`ifdef L0_LOADER_PERF_EN
   ,
   output logic [STALL_W-1:0] o_stall_cnt
`endif
);

   localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

   state_e            r_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_num;
   logic [ADDR_W-1:0] r_iss_cnt;
   logic [ADDR_W-1:0] r_wr_cnt;
   logic              r_inflight;
   logic              r_busy;
   logic              r_done;

   logic [1:0]        w_occ;
   logic [ROW*BW-1:0] w_head;
   logic              w_pop;
   logic [2:0]        w_pend;
   logic              w_issue;

   l0_skid_buf #(.WIDTH(ROW*BW)) u_skid (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (r_inflight),
      .i_din   (i_sram_q),
      .i_pop   (w_pop),
      .o_occ   (w_occ),
      .o_head  (w_head)
   );

   // Credit: buffered + in-flight minus this cycle's drain must leave room.
   assign w_pop   = (w_occ != 2'd0) && !i_l0_full;
   assign w_pend  = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
   assign w_issue = (r_state == RUN) && (w_pend < 3'd2);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= IDLE;
         r_base     <= '0;
         r_num      <= '0;
         r_iss_cnt  <= '0;
         r_wr_cnt   <= '0;
         r_inflight <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) r_iss_cnt <= r_iss_cnt + A_ONE;
         if (w_pop)   r_wr_cnt  <= r_wr_cnt + A_ONE;
         case (r_state)
            IDLE: if (i_start) begin
               r_base    <= i_base_addr;
               r_num     <= i_num_vec;
               r_iss_cnt <= '0;
               r_wr_cnt  <= '0;
               r_busy    <= (i_num_vec != '0);
               r_done    <= (i_num_vec == '0);
               r_state   <= (i_num_vec == '0) ? DONE : RUN;
            end
            RUN: if (w_issue && (r_iss_cnt == r_num - A_ONE)) r_state <= FLUSH;
            FLUSH: if (w_pop && (r_wr_cnt == r_num - A_ONE)) begin
               r_state <= DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_sram_cen  = ~w_issue;
   assign o_sram_addr = r_base + r_iss_cnt;
   assign o_l0_wr     = w_pop;
   assign o_l0_in     = w_head;

`ifdef L0_LOADER_PERF_EN
   logic [STALL_W-1:0] r_stall_cnt;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_stall_cnt <= '0;
      end else if ((r_state == IDLE) && i_start) begin
         r_stall_cnt <= '0;
      end else if ((w_occ != 2'd0) && i_l0_full && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
   end

   assign o_stall_cnt = r_stall_cnt;
`endif

endmodule
